// File: rtl/spi_flash_seq.sv
// spi_flash_seq
// Turns one user request into a complete SPI flash operation on top of the
// single-frame flash wrapper. The sequence is an optional write-enable frame
// (0x06), then the main frame, then optional read-status (0x05) polling until
// WIP clears or the poll timeout expires.
//
// Ports
//   clk, rstn                 clock, asynchronous active-low reset
//   req_*                     request handshake and fields, latched on accept
//   done_o / err_o / busy_o   end-of-operation pulse, timeout flag, activity
//   f_start_o, f_*_o          frame start pulse and frame fields to the wrapper
//   f_done_i                  end-of-frame pulse from the wrapper
//   f_rx_* / rx_*             RX words; passed straight through except while
//                             polling, when the sequencer consumes status words
module spi_flash_seq #(
    parameter int ADDR_W    = 24,
    parameter int NUM_CS    = 1,
    parameter int TIMEOUT_W = 20,
    parameter int POLL_GAP  = 16,
    localparam int CSW      = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [7:0]        req_cmd_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic              req_has_addr_i,
    input  logic [1:0]        req_mode_i,
    input  logic              req_rd_wr_i,
    input  logic [7:0]        req_count_i,
    input  logic [4:0]        req_dummy_i,
    input  logic [CSW-1:0]    req_cs_i,
    input  logic              req_wren_i,
    input  logic              req_poll_i,
    output logic              done_o,
    output logic              err_o,
    output logic              busy_o,
    output logic              f_start_o,
    output logic [7:0]        f_cmd_o,
    output logic [ADDR_W-1:0] f_addr_o,
    output logic              f_has_addr_o,
    output logic [1:0]        f_mode_o,
    output logic              f_rd_wr_o,
    output logic [7:0]        f_count_o,
    output logic [4:0]        f_dummy_o,
    output logic [CSW-1:0]    f_cs_o,
    input  logic              f_done_i,
    input  logic [31:0]       f_rx_data_i,
    input  logic              f_rx_valid_i,
    output logic              f_rx_ready_o,
    output logic [31:0]       rx_data_o,
    output logic              rx_valid_o,
    input  logic              rx_ready_i
);
    localparam int            GW       = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(POLL_GAP - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_WREN, S_WREN_W, S_MAIN, S_MAIN_W,
        S_POLL, S_POLL_W, S_POLL_RX, S_GAP, S_FIN
    } state_t;

    typedef struct packed {
        logic [7:0]        cmd;
        logic [ADDR_W-1:0] addr;
        logic              has_addr;
        logic [1:0]        mode;
        logic              rd_wr;
        logic [7:0]        count;
        logic [4:0]        dummy;
    } frame_t;

    localparam frame_t WREN_FR = '{cmd: 8'h06, addr: {ADDR_W{1'b0}}, has_addr: 1'b0,
                                   mode: 2'b00, rd_wr: 1'b0, count: 8'd0, dummy: 5'd0};
    localparam frame_t POLL_FR = '{cmd: 8'h05, addr: {ADDR_W{1'b0}}, has_addr: 1'b0,
                                   mode: 2'b01, rd_wr: 1'b1, count: 8'd0, dummy: 5'd0};

    state_t                 state;
    frame_t                 fr;       // frame currently presented to the wrapper
    frame_t                 main_fr;  // latched main frame
    frame_t                 req_fr;
    logic                   poll_req;
    logic                   poll_en;
    logic                   owned;
    logic [TIMEOUT_W-1:0]   tcnt;
    logic [GW-1:0]          gap_cnt;

    always_comb begin
        req_fr = '{cmd: req_cmd_i, addr: req_addr_i, has_addr: req_has_addr_i,
                   mode: req_mode_i, rd_wr: req_rd_wr_i, count: req_count_i,
                   dummy: req_dummy_i};
    end

    // A read that moves data cannot be followed by a status poll.
    assign poll_en = poll_req && (!main_fr.rd_wr || main_fr.mode == 2'b00);
    assign owned   = (state == S_POLL) || (state == S_POLL_W) ||
                     (state == S_POLL_RX) || (state == S_GAP);

    assign f_cmd_o      = fr.cmd;
    assign f_addr_o     = fr.addr;
    assign f_has_addr_o = fr.has_addr;
    assign f_mode_o     = fr.mode;
    assign f_rd_wr_o    = fr.rd_wr;
    assign f_count_o    = fr.count;
    assign f_dummy_o    = fr.dummy;

    // Status words never reach the user while polling.
    assign rx_data_o    = f_rx_data_i;
    assign rx_valid_o   = owned ? 1'b0 : f_rx_valid_i;
    assign f_rx_ready_o = owned ? (state == S_POLL_RX) : rx_ready_i;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= S_IDLE;
            fr          <= '0;
            main_fr     <= '0;
            poll_req    <= 1'b0;
            f_cs_o      <= '0;
            tcnt        <= '0;
            gap_cnt     <= '0;
            req_ready_o <= 1'b1;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
            f_start_o   <= 1'b0;
        end else begin
            f_start_o <= 1'b0;
            done_o    <= 1'b0;
            // Saturating timeout count; only inspected in POLL_RX.
            if (owned && !(&tcnt))
                tcnt <= tcnt + 1'b1;
            case (state)
                S_IDLE: if (req_valid_i) begin
                    main_fr     <= req_fr;
                    poll_req    <= req_poll_i;
                    f_cs_o      <= req_cs_i;
                    err_o       <= 1'b0;
                    req_ready_o <= 1'b0;
                    busy_o      <= 1'b1;
                    f_start_o   <= 1'b1;
                    if (req_wren_i) begin
                        fr    <= WREN_FR;
                        state <= S_WREN;
                    end else begin
                        fr    <= req_fr;
                        state <= S_MAIN;
                    end
                end
                S_WREN: state <= S_WREN_W;
                S_WREN_W: if (f_done_i) begin
                    fr        <= main_fr;
                    f_start_o <= 1'b1;
                    state     <= S_MAIN;
                end
                S_MAIN: state <= S_MAIN_W;
                S_MAIN_W: if (f_done_i) begin
                    if (poll_en) begin
                        fr        <= POLL_FR;
                        tcnt      <= '0;
                        f_start_o <= 1'b1;
                        state     <= S_POLL;
                    end else begin
                        done_o <= 1'b1;
                        state  <= S_FIN;
                    end
                end
                S_POLL: state <= S_POLL_W;
                S_POLL_W: if (f_done_i) state <= S_POLL_RX;
                S_POLL_RX: if (f_rx_valid_i) begin
                    if (!f_rx_data_i[0]) begin
                        done_o <= 1'b1;
                        state  <= S_FIN;
                    end else if (&tcnt) begin
                        done_o <= 1'b1;
                        err_o  <= 1'b1;
                        state  <= S_FIN;
                    end else begin
                        gap_cnt <= '0;
                        state   <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        f_start_o <= 1'b1;
                        state     <= S_POLL;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                S_FIN: begin
                    busy_o      <= 1'b0;
                    req_ready_o <= 1'b1;
                    state       <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_flash_seq.sv
// tb_spi_flash_seq
// Self-checking bench for spi_flash_seq. The bench plays both the user and the
// frame wrapper, one step per falling clock edge, and predicts every frame,
// pulse and flag from the operation rules: frame list from the request, poll
// enable, poll period, timeout from elapsed polling cycles.
module tb_spi_flash_seq;
    localparam int AW    = 32;
    localparam int NCS   = 4;
    localparam int TW    = 6;
    localparam int PG    = 4;
    localparam int LIMIT = (1 << TW) - 1;

    typedef struct packed {
        logic [7:0]    cmd;
        logic [AW-1:0] addr;
        logic          has_addr;
        logic [1:0]    mode;
        logic          rd_wr;
        logic [7:0]    count;
        logic [4:0]    dummy;
        logic [1:0]    cs;
    } frame_t;

    typedef struct packed {
        frame_t f;
        logic   wren;
        logic   poll;
    } req_t;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          req_valid_i = 1'b0;
    logic          req_ready_o;
    logic [7:0]    req_cmd_i = '0;
    logic [AW-1:0] req_addr_i = '0;
    logic          req_has_addr_i = 1'b0;
    logic [1:0]    req_mode_i = '0;
    logic          req_rd_wr_i = 1'b0;
    logic [7:0]    req_count_i = '0;
    logic [4:0]    req_dummy_i = '0;
    logic [1:0]    req_cs_i = '0;
    logic          req_wren_i = 1'b0;
    logic          req_poll_i = 1'b0;
    logic          done_o, err_o, busy_o, f_start_o;
    logic [7:0]    f_cmd_o;
    logic [AW-1:0] f_addr_o;
    logic          f_has_addr_o;
    logic [1:0]    f_mode_o;
    logic          f_rd_wr_o;
    logic [7:0]    f_count_o;
    logic [4:0]    f_dummy_o;
    logic [1:0]    f_cs_o;
    logic          f_done_i = 1'b0;
    logic [31:0]   f_rx_data_i = '0;
    logic          f_rx_valid_i = 1'b0;
    logic          f_rx_ready_o;
    logic [31:0]   rx_data_o;
    logic          rx_valid_o;
    logic          rx_ready_i = 1'b0;

    always #5 clk = ~clk;

    spi_flash_seq #(.ADDR_W(AW), .NUM_CS(NCS), .TIMEOUT_W(TW), .POLL_GAP(PG)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_cmd_i(req_cmd_i), .req_addr_i(req_addr_i), .req_has_addr_i(req_has_addr_i),
        .req_mode_i(req_mode_i), .req_rd_wr_i(req_rd_wr_i), .req_count_i(req_count_i),
        .req_dummy_i(req_dummy_i), .req_cs_i(req_cs_i), .req_wren_i(req_wren_i),
        .req_poll_i(req_poll_i),
        .done_o(done_o), .err_o(err_o), .busy_o(busy_o), .f_start_o(f_start_o),
        .f_cmd_o(f_cmd_o), .f_addr_o(f_addr_o), .f_has_addr_o(f_has_addr_o),
        .f_mode_o(f_mode_o), .f_rd_wr_o(f_rd_wr_o), .f_count_o(f_count_o),
        .f_dummy_o(f_dummy_o), .f_cs_o(f_cs_o), .f_done_i(f_done_i),
        .f_rx_data_i(f_rx_data_i), .f_rx_valid_i(f_rx_valid_i), .f_rx_ready_o(f_rx_ready_o),
        .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i)
    );

    frame_t obs;
    assign obs = {f_cmd_o, f_addr_o, f_has_addr_o, f_mode_o, f_rd_wr_o,
                  f_count_o, f_dummy_o, f_cs_o};

    int         ncmp = 0;
    int         nfail = 0;
    int         step = 0;
    int         polls = 0;
    logic [7:0] status_q[$];

    // The address is don't-care for frames that carry none.
    function automatic frame_t mask(input frame_t x, input logic ha);
        if (!ha) x.addr = '0;
        return x;
    endfunction

    function automatic req_t mk_req(input logic [7:0] cmd, input logic [AW-1:0] addr,
                                    input logic ha, input logic [1:0] mode, input logic rd,
                                    input logic [7:0] cnt, input logic [4:0] dmy,
                                    input logic [1:0] cs, input logic wren, input logic poll);
        req_t r;
        r.f = '{cmd: cmd, addr: addr, has_addr: ha, mode: mode, rd_wr: rd,
                count: cnt, dummy: dmy, cs: cs};
        r.wren = wren;
        r.poll = poll;
        return r;
    endfunction

    task automatic tick();
        @(negedge clk);
        step++;
    endtask

    task automatic drive_req(input req_t r);
        req_cmd_i      = r.f.cmd;
        req_addr_i     = r.f.addr;
        req_has_addr_i = r.f.has_addr;
        req_mode_i     = r.f.mode;
        req_rd_wr_i    = r.f.rd_wr;
        req_count_i    = r.f.count;
        req_dummy_i    = r.f.dummy;
        req_cs_i       = r.f.cs;
        req_wren_i     = r.wren;
        req_poll_i     = r.poll;
    endtask

    // Entered on the step where f_start_o is expected; returns on the step
    // after f_done_i was driven.
    task automatic do_frame(input frame_t e, input bit is_poll, input int lat, input string tag);
        frame_t em;
        em = mask(e, e.has_addr);
        ncmp++;
        if (f_start_o !== 1'b1) begin
            nfail++;
            $display("FAIL %s start: got %b want 1 (step %0d)", tag, f_start_o, step);
        end
        for (int i = 0; i <= lat; i++) begin
            ncmp++;
            if (mask(obs, e.has_addr) !== em) begin
                nfail++;
                $display("FAIL %s fields: got %h want %h (step %0d)", tag, mask(obs, e.has_addr), em, step);
            end
            f_done_i    = (i == lat);
            f_rx_data_i = $urandom;
            if (is_poll) begin
                f_rx_valid_i = 1'b1;
                rx_ready_i   = 1'b1;
                #1;
                ncmp++;
                if (rx_valid_o !== 1'b0 || f_rx_ready_o !== 1'b0) begin
                    nfail++;
                    $display("FAIL %s owned rx: got valid %b ready %b want 0 0", tag, rx_valid_o, f_rx_ready_o);
                end
            end else begin
                f_rx_valid_i = 1'($urandom_range(0, 1));
                rx_ready_i   = 1'($urandom_range(0, 1));
                #1;
                ncmp++;
                if (rx_valid_o !== f_rx_valid_i || f_rx_ready_o !== rx_ready_i || rx_data_o !== f_rx_data_i) begin
                    nfail++;
                    $display("FAIL %s rx pass: got v%b r%b d%h want v%b r%b d%h", tag, rx_valid_o,
                             f_rx_ready_o, rx_data_o, f_rx_valid_i, rx_ready_i, f_rx_data_i);
                end
            end
            tick();
            if (i < lat) begin
                ncmp++;
                if (f_start_o !== 1'b0 || done_o !== 1'b0) begin
                    nfail++;
                    $display("FAIL %s mid-frame: got start %b done %b want 0 0", tag, f_start_o, done_o);
                end
            end
        end
        f_done_i     = 1'b0;
        f_rx_valid_i = 1'b0;
        rx_ready_i   = 1'b0;
    endtask

    // Runs one complete operation from the accept step to the step after done_o.
    task automatic run_op(input req_t r, input bit keep_valid, input req_t nxt,
                          input bit abort_poll, input string tag);
        frame_t     wf, pf;
        bit         pen, err_exp;
        int         p, k, d;
        logic [7:0] sb;
        logic [31:0] w;
        wf = '{cmd: 8'h06, addr: '0, has_addr: 1'b0, mode: 2'b00, rd_wr: 1'b0,
               count: 8'd0, dummy: 5'd0, cs: r.f.cs};
        pf = '{cmd: 8'h05, addr: '0, has_addr: 1'b0, mode: 2'b01, rd_wr: 1'b1,
               count: 8'd0, dummy: 5'd0, cs: r.f.cs};
        pen     = r.poll && (!r.f.rd_wr || r.f.mode == 2'b00);
        err_exp = 1'b0;
        polls   = 0;

        drive_req(r);
        req_valid_i = 1'b1;
        ncmp++;
        if (req_ready_o !== 1'b1) begin
            nfail++;
            $display("FAIL %s ready at accept: got %b want 1", tag, req_ready_o);
        end
        tick();
        if (keep_valid) drive_req(nxt);
        else req_valid_i = 1'b0;
        ncmp++;
        if (busy_o !== 1'b1 || req_ready_o !== 1'b0 || err_o !== 1'b0) begin
            nfail++;
            $display("FAIL %s after accept: got busy %b ready %b err %b want 1 0 0", tag, busy_o, req_ready_o, err_o);
        end

        if (r.wren) do_frame(wf, 1'b0, $urandom_range(1, 4), {tag, " wren"});
        do_frame(r.f, 1'b0, $urandom_range(1, 5), {tag, " main"});

        if (pen) begin
            p = step;
            forever begin
                polls++;
                if (abort_poll) begin
                    ncmp++;
                    if (f_start_o !== 1'b1) begin
                        nfail++;
                        $display("FAIL %s poll start: got %b want 1", tag, f_start_o);
                    end
                    tick();
                    rstn = 1'b0;
                    #1;
                    ncmp++;
                    if (busy_o !== 1'b0 || req_ready_o !== 1'b1 || f_start_o !== 1'b0 || obs !== '0) begin
                        nfail++;
                        $display("FAIL %s reset mid-op: got busy %b ready %b start %b fields %h want 0 1 0 0",
                                 tag, busy_o, req_ready_o, f_start_o, obs);
                    end
                    tick();
                    rstn = 1'b1;
                    tick();
                    f_done_i = 1'b1;
                    tick();
                    f_done_i = 1'b0;
                    for (int j = 0; j < 2; j++) begin
                        ncmp++;
                        if (busy_o !== 1'b0 || f_start_o !== 1'b0 || req_ready_o !== 1'b1) begin
                            nfail++;
                            $display("FAIL %s stray done: got busy %b start %b ready %b want 0 0 1",
                                     tag, busy_o, f_start_o, req_ready_o);
                        end
                        tick();
                    end
                    return;
                end
                do_frame(pf, 1'b1, $urandom_range(1, 3), {tag, " poll"});
                d = $urandom_range(0, 2);
                for (int i = 0; i <= d; i++) begin
                    if (i == d) begin
                        sb = (status_q.size() != 0) ? status_q.pop_front() : 8'h01;
                        w = $urandom;
                        w[7:0] = sb;
                        f_rx_data_i  = w;
                        f_rx_valid_i = 1'b1;
                    end
                    rx_ready_i = 1'b0;
                    #1;
                    ncmp++;
                    if (f_rx_ready_o !== 1'b1 || rx_valid_o !== 1'b0 || done_o !== 1'b0) begin
                        nfail++;
                        $display("FAIL %s poll rx: got ready %b valid %b done %b want 1 0 0",
                                 tag, f_rx_ready_o, rx_valid_o, done_o);
                    end
                    k = step;
                    tick();
                end
                f_rx_valid_i = 1'b0;
                if (!sb[0]) break;
                if (k - p >= LIMIT) begin
                    err_exp = 1'b1;
                    break;
                end
                for (int j = 0; j < PG; j++) begin
                    ncmp++;
                    if (f_start_o !== 1'b0 || done_o !== 1'b0) begin
                        nfail++;
                        $display("FAIL %s gap: got start %b done %b want 0 0", tag, f_start_o, done_o);
                    end
                    tick();
                end
            end
        end

        ncmp++;
        if (done_o !== 1'b1 || err_o !== err_exp || busy_o !== 1'b1) begin
            nfail++;
            $display("FAIL %s done: got done %b err %b busy %b want 1 %b 1", tag, done_o, err_o, busy_o, err_exp);
        end
        tick();
        ncmp++;
        if (done_o !== 1'b0 || req_ready_o !== 1'b1 || busy_o !== 1'b0 || err_o !== err_exp) begin
            nfail++;
            $display("FAIL %s idle: got done %b ready %b busy %b err %b want 0 1 0 %b",
                     tag, done_o, req_ready_o, busy_o, err_o, err_exp);
        end
    endtask

    task automatic test_reset();
        tick();
        tick();
        ncmp++;
        if (req_ready_o !== 1'b1 || busy_o !== 1'b0 || done_o !== 1'b0 || err_o !== 1'b0 ||
            f_start_o !== 1'b0 || obs !== '0 || rx_valid_o !== 1'b0 || f_rx_ready_o !== 1'b0) begin
            nfail++;
            $display("FAIL reset: got ready %b busy %b done %b err %b start %b fields %h want 1 0 0 0 0 0",
                     req_ready_o, busy_o, done_o, err_o, f_start_o, obs);
        end
        rstn = 1'b1;
        tick();
        ncmp++;
        if (req_ready_o !== 1'b1 || busy_o !== 1'b0) begin
            nfail++;
            $display("FAIL reset release: got ready %b busy %b want 1 0", req_ready_o, busy_o);
        end
    endtask

    task automatic test_page_program();
        req_t r;
        r = mk_req(8'h02, 32'h0001_2345, 1'b1, 2'b01, 1'b0, 8'd3, 5'd0, 2'd0, 1'b1, 1'b1);
        status_q = '{8'h03, 8'h03, 8'h00};
        run_op(r, 1'b0, r, 1'b0, "page_prog");
        ncmp++;
        if (polls !== 3) begin
            nfail++;
            $display("FAIL page_prog polls: got %0d want 3", polls);
        end
    endtask

    task automatic test_quad_read();
        req_t r;
        r = mk_req(8'h6B, $urandom, 1'b1, 2'b11, 1'b1, 8'd7, 5'd8, 2'd1, 1'b0, 1'b1);
        status_q = '{};
        run_op(r, 1'b0, r, 1'b0, "quad_read");
        ncmp++;
        if (polls !== 0) begin
            nfail++;
            $display("FAIL quad_read polls: got %0d want 0", polls);
        end
    endtask

    task automatic test_timeout();
        req_t r, q;
        r = mk_req(8'hD8, 32'h0004_0000, 1'b1, 2'b01, 1'b0, 8'd0, 5'd0, 2'd3, 1'b1, 1'b1);
        status_q = '{};
        run_op(r, 1'b0, r, 1'b0, "timeout");
        tick();
        tick();
        ncmp++;
        if (err_o !== 1'b1) begin
            nfail++;
            $display("FAIL timeout err hold: got %b want 1", err_o);
        end
        q = mk_req(8'h9F, '0, 1'b0, 2'b01, 1'b1, 8'd2, 5'd0, 2'd0, 1'b0, 1'b0);
        run_op(q, 1'b0, q, 1'b0, "after_timeout");
    endtask

    task automatic test_sector_erase();
        req_t r;
        r = mk_req(8'h20, 32'hABCD_EF01, 1'b1, 2'b01, 1'b0, 8'd0, 5'd0, 2'd2, 1'b1, 1'b1);
        status_q = '{8'h01, 8'h00};
        run_op(r, 1'b0, r, 1'b0, "sector_erase");
    endtask

    task automatic test_reset_mid();
        req_t r;
        r = mk_req(8'h02, 32'h0000_1000, 1'b1, 2'b01, 1'b0, 8'd15, 5'd0, 2'd1, 1'b1, 1'b1);
        status_q = '{};
        run_op(r, 1'b0, r, 1'b1, "reset_mid");
    endtask

    task automatic test_back_to_back();
        req_t a, b;
        f_done_i = 1'b1;
        tick();
        f_done_i = 1'b0;
        ncmp++;
        if (busy_o !== 1'b0 || f_start_o !== 1'b0 || req_ready_o !== 1'b1) begin
            nfail++;
            $display("FAIL idle stray done: got busy %b start %b ready %b want 0 0 1", busy_o, f_start_o, req_ready_o);
        end
        a = mk_req(8'h02, 32'h0010_0000, 1'b1, 2'b01, 1'b0, 8'd0, 5'd0, 2'd1, 1'b1, 1'b1);
        b = mk_req(8'h3B, 32'h0020_0040, 1'b1, 2'b10, 1'b1, 8'd4, 5'd8, 2'd2, 1'b0, 1'b0);
        status_q = '{8'h01, 8'h00};
        run_op(a, 1'b1, b, 1'b0, "b2b_first");
        run_op(b, 1'b0, b, 1'b0, "b2b_second");
    endtask

    task automatic test_random();
        req_t r;
        int   n;
        for (int t = 0; t < 25; t++) begin
            r = mk_req(8'($urandom), $urandom, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                       1'($urandom_range(0, 1)), 8'($urandom), 5'($urandom), 2'($urandom_range(0, 3)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            status_q = '{};
            n = $urandom_range(0, 3);
            for (int j = 0; j < n; j++) status_q.push_back(8'(($urandom_range(0, 127) << 1) | 1));
            status_q.push_back(8'($urandom_range(0, 127) << 1));
            run_op(r, 1'b0, r, 1'b0, "random");
            if ($urandom_range(0, 1) == 1) tick();
        end
    endtask

    initial begin
        test_reset();
        test_page_program();
        test_quad_read();
        test_timeout();
        test_sector_erase();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: run did not end by step %0d", step);
        $fatal(1, "watchdog expired");
    end
endmodule
